// File: rtl/sccb_slave_if.sv
// sccb_slave_if
// Bundles the SCCB line signals and the register-file side of sccb_slave.
//   sio_c, sio_d_r    : SCCB clock and sampled data line (asynchronous)
//   sio_d_wr(_en)     : data the target drives onto sio_d, and its tri-state enable
//   reg_addr          : latched 16-bit register address
//   reg_wr_data/_en   : write data and one-cycle write strobe
//   reg_rd_en         : one-cycle read strobe
//   reg_rd_data       : read data, valid the cycle after reg_rd_en
//   busy, id_err      : frame in progress; device ID mismatch pulse
// Modport slave is used by the target; modport master by whatever drives the bus.
`timescale 1ns/1ps
interface sccb_slave_if;
  logic        sio_c;
  logic        sio_d_r;
  logic        sio_d_wr;
  logic        sio_d_wr_en;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wr_data;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [7:0]  reg_rd_data;
  logic        busy;
  logic        id_err;

  modport slave (
    input  sio_c, sio_d_r, reg_rd_data,
    output sio_d_wr, sio_d_wr_en, reg_addr, reg_wr_data, reg_wr_en,
           reg_rd_en, busy, id_err
  );

  modport master (
    output sio_c, sio_d_r, reg_rd_data,
    input  sio_d_wr, sio_d_wr_en, reg_addr, reg_wr_data, reg_wr_en,
           reg_rd_en, busy, id_err
  );
endinterface

// File: rtl/sccb_slave.sv
// sccb_slave
// SCCB target: decodes START/STOP, device ID, 16-bit register address and
// 8-bit data; issues single-cycle register write/read strobes and shifts
// read data back out on sio_d.
// Ports: clk, rst_n (asynchronous, active-low), bus (sccb_slave_if.slave).
// Optional build macro SCCB_SLAVE_ACK_EN: drive an I2C-style ACK (0) in the
// ninth bit of a matched ID, both address bytes and the write data byte.
// Without it the ninth bit is never driven.
`timescale 1ns/1ps
module sccb_slave #(
  parameter logic [7:0] DEV_ID      = 8'h78,
  parameter int         SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst_n,
  sccb_slave_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_X, AH, AH_X, AL, AL_X, WD, WD_X, RD, RD_X, WAIT_STOP
  } state_t;

  localparam logic [7:0] RD_ID = DEV_ID | 8'h01;

  state_t state, state_nxt;
  logic [2:0] bit_cnt;
  logic [SYNC_STAGES-1:0] scl_sync_p0, sda_sync_p0;
  logic scl_p1, sda_p1;
  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;
  logic [6:0] rx_sh;
  logic [7:0] rx_byte, id_q, tx_sh;
  logic cnt_clr, cnt_inc, ld_id, ld_ah, ld_al, ld_wd, id_bad, rd_req;
  logic tx_first, tx_next, drv_off, ack_on;
  logic rd_cap_p0;
  logic sd_wr, sd_en, wr_en, rd_en, busy_q, id_err_q;
  logic [15:0] addr_q;
  logic [7:0] wr_data_q;

  // Stage 0: synchronisers; stage 1: one extra flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_p0 <= '1;
      sda_sync_p0 <= '1;
      scl_p1      <= 1'b1;
      sda_p1      <= 1'b1;
    end else begin
      scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], bus.sio_c};
      sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], bus.sio_d_r};
      scl_p1      <= scl_sync_p0[SYNC_STAGES-1];
      sda_p1      <= sda_sync_p0[SYNC_STAGES-1];
    end
  end

  assign scl       = scl_sync_p0[SYNC_STAGES-1];
  assign sda       = sda_sync_p0[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_p1;
  assign scl_fall  = ~scl & scl_p1;
  assign start_det = scl & sda_p1 & ~sda;
  assign stop_det  = scl & ~sda_p1 & sda;
  assign rx_byte   = {rx_sh, sda};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)      bit_cnt <= 3'd0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Byte states count 8 rises (counter wraps to 0 on entering _X). In an _X
  // state the counter marks whether the ninth rise has been seen, so the
  // first fall (start of bit 9) and the exit fall can be told apart.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    ld_id     = 1'b0;
    ld_ah     = 1'b0;
    ld_al     = 1'b0;
    ld_wd     = 1'b0;
    id_bad    = 1'b0;
    rd_req    = 1'b0;
    tx_first  = 1'b0;
    tx_next   = 1'b0;
    drv_off   = 1'b0;
    ack_on    = 1'b0;
    if (stop_det) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
      drv_off   = 1'b1;
    end else if (start_det) begin
      state_nxt = ID;
      cnt_clr   = 1'b1;
      drv_off   = 1'b1;
    end else begin
      case (state)
        ID, AH, AL, WD: begin
          if (scl_rise) begin
            cnt_inc = 1'b1;
            if (bit_cnt == 3'd7) begin
              case (state)
                ID: begin
                  state_nxt = ID_X;
                  ld_id     = 1'b1;
                  id_bad    = (rx_byte != DEV_ID) && (rx_byte != RD_ID);
                end
                AH: begin state_nxt = AH_X; ld_ah = 1'b1; end
                AL: begin state_nxt = AL_X; ld_al = 1'b1; end
                default: begin state_nxt = WD_X; ld_wd = 1'b1; end
              endcase
            end
          end
        end
        ID_X, AH_X, AL_X, WD_X, RD_X: begin
          if (scl_rise && bit_cnt == 3'd0) begin
            cnt_inc = 1'b1;
            rd_req  = (state == ID_X) && (id_q == RD_ID);
          end else if (scl_fall && bit_cnt == 3'd1) begin
            cnt_clr = 1'b1;
            drv_off = 1'b1;
            case (state)
              ID_X: begin
                if (id_q == DEV_ID) begin
                  state_nxt = AH;
                end else if (id_q == RD_ID) begin
                  // Keep driving: bit 7 of read data replaces the ninth bit
                  state_nxt = RD;
                  drv_off   = 1'b0;
                  tx_first  = 1'b1;
                end else begin
                  state_nxt = WAIT_STOP;
                end
              end
              AH_X:    state_nxt = AL;
              AL_X:    state_nxt = WD;
              default: state_nxt = WAIT_STOP;
            endcase
          end
`ifdef SCCB_SLAVE_ACK_EN
          else if (scl_fall && bit_cnt == 3'd0 && state != RD_X &&
                   (state != ID_X || id_q == DEV_ID || id_q == RD_ID)) begin
            ack_on = 1'b1;
          end
`endif
        end
        RD: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              // Release the line for the master's NA bit
              state_nxt = RD_X;
              cnt_clr   = 1'b1;
              drv_off   = 1'b1;
            end else begin
              cnt_inc = 1'b1;
              tx_next = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stage 2: control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_wr     <= 1'b1;
      sd_en     <= 1'b0;
      addr_q    <= 16'h0000;
      wr_data_q <= 8'h00;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      rd_cap_p0 <= 1'b0;
      busy_q    <= 1'b0;
      id_err_q  <= 1'b0;
    end else begin
      wr_en     <= ld_wd;
      rd_en     <= rd_req;
      rd_cap_p0 <= rd_en;
      id_err_q  <= id_bad;
      if (ld_ah) addr_q[15:8] <= rx_byte;
      if (ld_al) addr_q[7:0]  <= rx_byte;
      if (ld_wd) wr_data_q    <= rx_byte;
      if (start_det)     busy_q <= 1'b1;
      else if (stop_det) busy_q <= 1'b0;
      if (drv_off) begin
        sd_en <= 1'b0;
        sd_wr <= 1'b1;
      end
      if (ack_on) begin
        sd_en <= 1'b1;
        sd_wr <= 1'b0;
      end
      if (tx_first || tx_next) begin
        sd_en <= 1'b1;
        sd_wr <= tx_sh[7];
      end
    end
  end

  // Data shift registers carry no reset; they are always reloaded before use
  always_ff @(posedge clk) begin
    if (scl_rise) rx_sh <= rx_byte[6:0];
    if (ld_id)    id_q  <= rx_byte;
    if (rd_cap_p0)                tx_sh <= bus.reg_rd_data;
    else if (tx_first || tx_next) tx_sh <= {tx_sh[6:0], 1'b1};
  end

  assign bus.sio_d_wr    = sd_wr;
  assign bus.sio_d_wr_en = sd_en;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wr_data = wr_data_q;
  assign bus.reg_wr_en   = wr_en;
  assign bus.reg_rd_en   = rd_en;
  assign bus.busy        = busy_q;
  assign bus.id_err      = id_err_q;

endmodule

// File: tb/tb_sccb_slave.sv
// tb_sccb_slave
// Directed bench for sccb_slave: bit-banged SCCB master, open-drain line model,
// scoreboard of expected register write/read strobes.
`timescale 1ns/1ps
module tb_sccb_slave;
  localparam int T    = 100;  // quarter SCL period in ns
  localparam int SCLK = 40;   // clk cycles per SCL period
`ifdef SCCB_SLAVE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_sda = 1'b1;

  sccb_slave_if bus();

  sccb_slave #(.DEV_ID(8'h78), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Wired-AND of master and target drivers
  assign bus.sio_d_r = m_sda & (bus.sio_d_wr_en ? bus.sio_d_wr : 1'b1);

  // Register file model: read data appears the cycle after reg_rd_en
  always @(posedge clk) bus.reg_rd_data <= bus.reg_rd_en ? 8'h56 : 8'h00;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int id_err_cnt = 0;
  logic [23:0] obs_wr[$];
  logic [15:0] obs_rd[$];
  logic [23:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  int wr_idx = 0;
  int rd_idx = 0;

  always @(posedge clk) begin
    if (bus.sio_d_wr_en === 1'b1) en_cnt++;
    if (bus.id_err === 1'b1) id_err_cnt++;
    if (bus.reg_wr_en === 1'b1) obs_wr.push_back({bus.reg_addr, bus.reg_wr_data});
    if (bus.reg_rd_en === 1'b1) obs_rd.push_back(bus.reg_addr);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int v, input int lo, input int hi);
    checks++;
    assert (v >= lo && v <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic check_sb(input string tag);
    check($sformatf("%s_wr_count", tag), 32'(obs_wr.size() - wr_idx), 32'(exp_wr.size()));
    while (exp_wr.size() > 0 && wr_idx < obs_wr.size()) begin
      check($sformatf("%s_wr", tag), 32'(obs_wr[wr_idx]), 32'(exp_wr.pop_front()));
      wr_idx++;
    end
    wr_idx = obs_wr.size();
    exp_wr.delete();
    check($sformatf("%s_rd_count", tag), 32'(obs_rd.size() - rd_idx), 32'(exp_rd.size()));
    while (exp_rd.size() > 0 && rd_idx < obs_rd.size()) begin
      check($sformatf("%s_rd", tag), 32'(obs_rd[rd_idx]), 32'(exp_rd.pop_front()));
      rd_idx++;
    end
    rd_idx = obs_rd.size();
    exp_rd.delete();
  endtask

  task automatic sccb_start();
    m_sda = 1'b1; bus.sio_c = 1'b1; #T;
    m_sda = 1'b0; #T;
    bus.sio_c = 1'b0; #T;
  endtask

  task automatic sccb_stop();
    m_sda = 1'b0; #T;
    bus.sio_c = 1'b1; #T;
    m_sda = 1'b1; #T;
  endtask

  task automatic sccb_bit(input logic b, output logic s, output logic e);
    m_sda = b; #T;
    bus.sio_c = 1'b1; #T;
    s = bus.sio_d_r;
    e = bus.sio_d_wr_en;
    #T;
    bus.sio_c = 1'b0; #T;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit exp_ack, input string tag);
    logic s, e;
    for (int i = 7; i >= 0; i--) begin
      sccb_bit(b[i], s, e);
      check($sformatf("%s_b%0d_en", tag, i), 32'(e), 32'(0));
    end
    sccb_bit(1'b1, s, e);
    check($sformatf("%s_ack_en", tag), 32'(e), 32'(ACK && exp_ack));
    check($sformatf("%s_ack_sda", tag), 32'(s), 32'(!(ACK && exp_ack)));
  endtask

  task automatic read_byte(input logic [7:0] exp, input string tag);
    logic s, e;
    for (int i = 7; i >= 0; i--) begin
      sccb_bit(1'b1, s, e);
      check($sformatf("%s_bit%0d", tag, i), 32'(s), 32'(exp[i]));
      check($sformatf("%s_bit%0d_en", tag, i), 32'(e), 32'(1));
    end
    sccb_bit(1'b1, s, e);
    check($sformatf("%s_na_en", tag), 32'(e), 32'(0));
  endtask

  initial begin
    int e0;
    int i0;
    logic s, e;
    bus.sio_c = 1'b1;
    m_sda = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_sio_d_wr", 32'(bus.sio_d_wr), 32'(1));
    check("rst_sio_d_wr_en", 32'(bus.sio_d_wr_en), 32'(0));
    check("rst_reg_addr", 32'(bus.reg_addr), 32'(0));
    check("rst_reg_wr_data", 32'(bus.reg_wr_data), 32'(0));
    check("rst_reg_wr_en", 32'(bus.reg_wr_en), 32'(0));
    check("rst_reg_rd_en", 32'(bus.reg_rd_en), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_id_err", 32'(bus.id_err), 32'(0));
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Write 16'h3008 = 8'h42
    e0 = en_cnt;
    exp_wr.push_back({16'h3008, 8'h42});
    sccb_start();
    write_byte(8'h78, 1'b1, "w1_id");
    check("w1_busy", 32'(bus.busy), 32'(1));
    write_byte(8'h30, 1'b1, "w1_ah");
    write_byte(8'h08, 1'b1, "w1_al");
    write_byte(8'h42, 1'b1, "w1_wd");
    sccb_stop();
    check("w1_busy_end", 32'(bus.busy), 32'(0));
    check_rng("w1_en_cycles", en_cnt - e0, ACK ? 4*SCLK-4 : 0, ACK ? 4*SCLK+4 : 0);
    check_sb("w1");

    // Read 16'h300A: address phase, STOP, then read ID
    exp_rd.push_back(16'h300A);
    sccb_start();
    write_byte(8'h78, 1'b1, "r1_id");
    write_byte(8'h30, 1'b1, "r1_ah");
    write_byte(8'h0A, 1'b1, "r1_al");
    sccb_stop();
    e0 = en_cnt;
    sccb_start();
    write_byte(8'h79, 1'b1, "r1_rid");
    read_byte(8'h56, "r1");
    sccb_stop();
    check_rng("r1_en_cycles", en_cnt - e0, (ACK ? 9 : 8)*SCLK-4, (ACK ? 9 : 8)*SCLK+4);
    check_sb("r1");

    // Wrong device ID followed by three bytes
    e0 = en_cnt;
    i0 = id_err_cnt;
    sccb_start();
    write_byte(8'h42, 1'b0, "bad_id");
    write_byte(8'h11, 1'b0, "bad_b1");
    write_byte(8'h22, 1'b0, "bad_b2");
    write_byte(8'h33, 1'b0, "bad_b3");
    sccb_stop();
    check("bad_id_err_pulses", 32'(id_err_cnt - i0), 32'(1));
    check("bad_en_cycles", 32'(en_cnt - e0), 32'(0));
    check("bad_reg_addr", 32'(bus.reg_addr), 32'(16'h300A));
    check_sb("bad");

    // STOP after 5 bits of the low address byte, then a full write
    sccb_start();
    write_byte(8'h78, 1'b1, "ab_id");
    write_byte(8'h12, 1'b1, "ab_ah");
    for (int i = 7; i >= 3; i--) sccb_bit(i[0] ? 1'b0 : 1'b1, s, e);
    sccb_stop();
    check_sb("abort");
    exp_wr.push_back({16'h1234, 8'hA5});
    sccb_start();
    write_byte(8'h78, 1'b1, "w2_id");
    write_byte(8'h12, 1'b1, "w2_ah");
    write_byte(8'h34, 1'b1, "w2_al");
    write_byte(8'hA5, 1'b1, "w2_wd");
    sccb_stop();
    check_sb("w2");
    check("w2_reg_addr", 32'(bus.reg_addr), 32'(16'h1234));

    // Reset asserted during read data bit 3
    exp_rd.push_back(16'h1234);
    sccb_start();
    write_byte(8'h79, 1'b1, "rr_rid");
    for (int i = 7; i >= 4; i--) begin
      sccb_bit(1'b1, s, e);
      check($sformatf("rr_bit%0d", i), 32'(s), 32'(i == 6 || i == 4));
    end
    m_sda = 1'b1; #T;
    bus.sio_c = 1'b1; #T;
    check("rr_pre_rst_en", 32'(bus.sio_d_wr_en), 32'(1));
    rst_n = 1'b0;
    #1;
    check("rr_rst_en", 32'(bus.sio_d_wr_en), 32'(0));
    check("rr_rst_busy", 32'(bus.busy), 32'(0));
    #(T-1);
    bus.sio_c = 1'b0; #T;
    sccb_stop();
    check_sb("rr");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rr_reg_addr_cleared", 32'(bus.reg_addr), 32'(0));

    // Write after reset
    exp_wr.push_back({16'h0001, 8'h01});
    sccb_start();
    write_byte(8'h78, 1'b1, "w3_id");
    write_byte(8'h00, 1'b1, "w3_ah");
    write_byte(8'h01, 1'b1, "w3_al");
    write_byte(8'h01, 1'b1, "w3_wd");
    sccb_stop();
    check_sb("w3");
    check("w3_busy_end", 32'(bus.busy), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
